fifo_serial_tx: RTL and testbench

Consumer-side drain for the project's two-entry FIFO: pops items from the FIFO's read port and transmits each one as a framed, LSB-first serial word on a single line. It connects directly to the FIFO's `empty`, `item_out` and `read` signals. It sits between the FIFO and an off-block serial link, with the same clock and reset as the FIFO.

---
 rtl/fifo_serial_tx.sv | 123 ++++++++++++
 tb/tb_fifo_serial_tx.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_serial_tx.sv
// fifo_serial_tx: pops items from a FIFO read port and sends each one as a
// framed, LSB-first serial word (start, data, optional even parity, stop).
module fifo_serial_tx #(
    parameter int SIZE       = 2,
    parameter int BIT_PERIOD = 4,
    parameter int PARITY     = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            empty,
    input  logic [SIZE-1:0] item_in,
    output logic            read,
    output logic            tx,
    output logic            busy,
    output logic [7:0]      frame_count
);
    localparam int TW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
    localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(BIT_PERIOD - 1);
    localparam logic [IW-1:0] I_LAST = IW'(SIZE - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t          state, state_d;
    logic [TW-1:0]   timer, timer_d;
    logic [IW-1:0]   idx, idx_d;
    logic [SIZE-1:0] shreg, shreg_d;
    logic            par_bit, par_bit_d;
    logic            tx_d;
    logic            bit_end;
    logic            last_stop;
    logic            load;

    assign bit_end   = (timer == T_LAST);
    assign last_stop = (state == STOP) && bit_end;
    assign load      = en && !empty && ((state == IDLE) || last_stop);

    // State, datapath and line registers; reset abandons any partial frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            timer       <= '0;
            idx         <= '0;
            shreg       <= '0;
            par_bit     <= 1'b0;
            tx          <= 1'b1;
            frame_count <= '0;
        end else begin
            state   <= state_d;
            timer   <= timer_d;
            idx     <= idx_d;
            shreg   <= shreg_d;
            par_bit <= par_bit_d;
            tx      <= tx_d;
            if (last_stop) begin
                frame_count <= frame_count + 8'd1;
            end
        end
    end

    // Next-state and next-datapath values; a load overrides the bit sequencing
    always_comb begin
        state_d   = state;
        timer_d   = timer;
        idx_d     = idx;
        shreg_d   = shreg;
        par_bit_d = par_bit;
        if (state != IDLE) begin
            timer_d = bit_end ? '0 : timer + 1'b1;
        end
        case (state)
            IDLE:  state_d = IDLE;
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shreg_d = shreg >> 1;
                    if (idx == I_LAST) begin
                        idx_d   = '0;
                        state_d = (PARITY != 0) ? PAR : STOP;
                    end else begin
                        idx_d = idx + 1'b1;
                    end
                end
            end
            PAR: begin
                if (bit_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            state_d   = START;
            timer_d   = '0;
            idx_d     = '0;
            shreg_d   = item_in;
            par_bit_d = ^item_in;
        end
    end

    // Outputs: pop request, busy flag, and the line value for the upcoming cycle
    always_comb begin
        read = load && !reset;
        busy = (state != IDLE);
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            PAR:     tx_d = par_bit_d;
            default: tx_d = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_fifo_serial_tx.sv
// tb_fifo_serial_tx: three parameterisations of fifo_serial_tx fed from
// behavioural two-entry FIFOs; a line receiver decodes each frame and checks
// it against a scoreboard of pushed items.
module tb_fifo_serial_tx;
    localparam int NI = 3;

    logic       clk, reset, en;
    logic       empty_l [NI];
    logic [1:0] it0, it1;
    logic [2:0] it2;
    logic       read_l [NI];
    logic       tx_l [NI];
    logic       busy_l [NI];
    logic [7:0] fc_l [NI];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [2:0] fq [NI][2];
    int         fn [NI];
    logic [2:0] eq [NI][8];
    int         eh [NI];
    int         et [NI];
    bit         pend_rd [NI];
    int         rd_cnt [NI];
    int         last_rd [NI];
    int         prev_rd [NI];

    bit   in_frame [NI];
    int   ns [NI];
    logic smp [NI][64];
    bit   busy_ok [NI];
    bit   pend_fc [NI];
    int   exp_cnt [NI];
    int   frames [NI];

    fifo_serial_tx #(.SIZE(2), .BIT_PERIOD(4), .PARITY(0)) dut0 (
        .clk(clk), .reset(reset), .en(en), .empty(empty_l[0]), .item_in(it0),
        .read(read_l[0]), .tx(tx_l[0]), .busy(busy_l[0]), .frame_count(fc_l[0]));
    fifo_serial_tx #(.SIZE(2), .BIT_PERIOD(4), .PARITY(1)) dut1 (
        .clk(clk), .reset(reset), .en(en), .empty(empty_l[1]), .item_in(it1),
        .read(read_l[1]), .tx(tx_l[1]), .busy(busy_l[1]), .frame_count(fc_l[1]));
    fifo_serial_tx #(.SIZE(3), .BIT_PERIOD(1), .PARITY(1)) dut2 (
        .clk(clk), .reset(reset), .en(en), .empty(empty_l[2]), .item_in(it2),
        .read(read_l[2]), .tx(tx_l[2]), .busy(busy_l[2]), .frame_count(fc_l[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int sz_of(int i);
        return (i == 2) ? 3 : 2;
    endfunction
    function automatic int bp_of(int i);
        return (i == 2) ? 1 : 4;
    endfunction
    function automatic int par_of(int i);
        return (i == 0) ? 0 : 1;
    endfunction
    function automatic int flen(int i);
        return (2 + sz_of(i) + par_of(i)) * bp_of(i);
    endfunction

    task automatic chk(string name, int got, int expv);
        checks++;
        if (got != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, expv, cyc);
        end
    endtask

    task automatic push(int i, logic [2:0] v);
        logic [2:0] m;
        m = v & 3'((1 << sz_of(i)) - 1);
        if (fn[i] < 2) begin
            fq[i][fn[i]] = m;
            fn[i]++;
            eq[i][et[i]] = m;
            et[i] = (et[i] + 1) % 8;
        end
    endtask

    task automatic drive_items();
        for (int i = 0; i < NI; i++) empty_l[i] = (fn[i] == 0);
        it0 = fq[0][0][1:0];
        it1 = fq[1][0][1:0];
        it2 = fq[2][0];
    endtask

    // One clock: settle inputs, sample the combinational pop, advance to the next falling edge
    task automatic tick();
        drive_items();
        #1;
        for (int i = 0; i < NI; i++) begin
            pend_rd[i] = read_l[i];
            if (read_l[i]) begin
                chk($sformatf("read_nonempty[%0d]", i), empty_l[i], 0);
                rd_cnt[i]++;
                prev_rd[i] = last_rd[i];
                last_rd[i] = cyc;
            end
        end
        @(negedge clk);
        cyc++;
        for (int i = 0; i < NI; i++) begin
            if (pend_rd[i] && fn[i] > 0) begin
                fq[i][0] = fq[i][1];
                fn[i]--;
            end
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rst_tx[%0d]", i), tx_l[i], 1);
            chk($sformatf("rst_busy[%0d]", i), busy_l[i], 0);
            chk($sformatf("rst_fc[%0d]", i), fc_l[i], 0);
            chk($sformatf("rst_read[%0d]", i), read_l[i], 0);
            fn[i] = 0;
            eh[i] = et[i];
            pend_rd[i] = 1'b0;
        end
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic finish_frame(int i);
        int nb;
        int bp;
        int got;
        int expv;
        bit hold_ok;
        logic [2:0] item;
        nb = 2 + sz_of(i) + par_of(i);
        bp = bp_of(i);
        got = 0;
        expv = 0;
        hold_ok = 1'b1;
        item = '0;
        chk($sformatf("frame_expected[%0d]", i), int'(eh[i] != et[i]), 1);
        if (eh[i] != et[i]) begin
            item = eq[i][eh[i]];
            eh[i] = (eh[i] + 1) % 8;
        end
        for (int b = 0; b < nb; b++) begin
            if (smp[i][b * bp] === 1'b1) got |= (1 << b);
            for (int s = 1; s < bp; s++) begin
                if (smp[i][b * bp + s] !== smp[i][b * bp]) hold_ok = 1'b0;
            end
        end
        // start 0, data LSB first, optional even parity, stop 1
        for (int d = 0; d < sz_of(i); d++) begin
            if (item[d]) expv |= (1 << (1 + d));
        end
        if (par_of(i) != 0 && (^item)) expv |= (1 << (1 + sz_of(i)));
        expv |= (1 << (nb - 1));
        chk($sformatf("frame_bits[%0d]", i), got, expv);
        chk($sformatf("bit_hold[%0d]", i), int'(hold_ok), 1);
        chk($sformatf("busy_in_frame[%0d]", i), int'(busy_ok[i]), 1);
        exp_cnt[i] = (exp_cnt[i] + 1) % 256;
        pend_fc[i] = 1'b1;
        frames[i]++;
    endtask

    // Line receiver: collect a whole frame of per-cycle samples after each falling start edge
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (reset) begin
                in_frame[i] = 1'b0;
                pend_fc[i] = 1'b0;
                exp_cnt[i] = 0;
            end else begin
                if (pend_fc[i]) begin
                    chk($sformatf("frame_count[%0d]", i), fc_l[i], exp_cnt[i]);
                    pend_fc[i] = 1'b0;
                end
                if (!in_frame[i] && tx_l[i] == 1'b0) begin
                    in_frame[i] = 1'b1;
                    ns[i] = 0;
                    busy_ok[i] = 1'b1;
                end
                if (in_frame[i]) begin
                    smp[i][ns[i]] = tx_l[i];
                    if (busy_l[i] !== 1'b1) busy_ok[i] = 1'b0;
                    ns[i]++;
                    if (ns[i] == flen(i)) begin
                        finish_frame(i);
                        in_frame[i] = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base [NI];
        int fc0 [NI];
        int bcnt [NI];
        int bfirst [NI];
        int blast [NI];
        bit bad [NI];
        int f0;
        int k;

        reset = 1'b1;
        en = 1'b0;
        for (int i = 0; i < NI; i++) begin
            fn[i] = 0;
            fq[i][0] = '0;
            fq[i][1] = '0;
        end
        drive_items();
        @(negedge clk);
        apply_reset();

        // single frame
        en = 1'b1;
        for (int i = 0; i < NI; i++) begin
            base[i] = rd_cnt[i];
            push(i, 3'b010);
        end
        repeat (25) tick();
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("single_read_pulse[%0d]", i), rd_cnt[i] - base[i], 1);
            chk($sformatf("single_fifo_empty[%0d]", i), fn[i], 0);
            chk($sformatf("single_fc[%0d]", i), fc_l[i], 1);
        end

        // parity items, two queued together
        for (int i = 0; i < NI; i++) begin
            base[i] = rd_cnt[i];
            push(i, 3'b001);
            push(i, 3'b011);
        end
        repeat (50) tick();
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("parity_reads[%0d]", i), rd_cnt[i] - base[i], 2);
            chk($sformatf("read_spacing[%0d]", i), last_rd[i] - prev_rd[i], flen(i));
        end

        // back-to-back from a full FIFO
        en = 1'b0;
        for (int i = 0; i < NI; i++) begin
            push(i, 3'b001);
            push(i, 3'b010);
            fc0[i] = fc_l[i];
            bcnt[i] = 0;
            bfirst[i] = -1;
            blast[i] = -1;
        end
        repeat (3) tick();
        en = 1'b1;
        for (int c = 0; c < 60; c++) begin
            tick();
            for (int i = 0; i < NI; i++) begin
                if (busy_l[i]) begin
                    bcnt[i]++;
                    if (bfirst[i] < 0) bfirst[i] = c;
                    blast[i] = c;
                end
            end
        end
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("b2b_busy_cycles[%0d]", i), bcnt[i], 2 * flen(i));
            chk($sformatf("b2b_busy_contig[%0d]", i), blast[i] - bfirst[i] + 1, bcnt[i]);
            chk($sformatf("b2b_read_spacing[%0d]", i), last_rd[i] - prev_rd[i], flen(i));
            chk($sformatf("b2b_fc[%0d]", i), fc_l[i], (fc0[i] + 2) % 256);
        end

        // en gating
        en = 1'b0;
        for (int i = 0; i < NI; i++) begin
            push(i, 3'($urandom_range(0, 7)));
            base[i] = rd_cnt[i];
            bad[i] = 1'b0;
        end
        for (int c = 0; c < 50; c++) begin
            tick();
            for (int i = 0; i < NI; i++) begin
                if (tx_l[i] !== 1'b1 || busy_l[i] !== 1'b0 || pend_rd[i]) bad[i] = 1'b1;
            end
        end
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("en0_quiet[%0d]", i), int'(bad[i]), 0);
            chk($sformatf("en0_no_read[%0d]", i), rd_cnt[i] - base[i], 0);
            fc0[i] = fc_l[i];
        end
        en = 1'b1;
        tick();
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("en_rise_read[%0d]", i), rd_cnt[i] - base[i], 1);
            chk($sformatf("en_rise_tx_start[%0d]", i), tx_l[i], 0);
        end
        repeat (3) tick();
        en = 1'b0;
        for (int i = 0; i < NI; i++) push(i, 3'($urandom_range(0, 7)));
        repeat (40) tick();
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("en_drop_one_frame[%0d]", i), rd_cnt[i] - base[i], 1);
            chk($sformatf("en_drop_fc[%0d]", i), fc_l[i], (fc0[i] + 1) % 256);
        end

        // reset during data bit 1
        en = 1'b1;
        tick();
        repeat (9) tick();
        apply_reset();
        for (int i = 0; i < NI; i++) begin
            base[i] = rd_cnt[i];
            bad[i] = 1'b0;
        end
        for (int c = 0; c < 30; c++) begin
            tick();
            for (int i = 0; i < NI; i++) begin
                if (tx_l[i] !== 1'b1 || busy_l[i] !== 1'b0) bad[i] = 1'b1;
            end
        end
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("post_reset_quiet[%0d]", i), int'(bad[i]), 0);
            chk($sformatf("post_reset_no_read[%0d]", i), rd_cnt[i] - base[i], 0);
        end

        // random traffic long enough to wrap frame_count
        f0 = frames[0];
        k = 0;
        while (k < 20000 && (frames[0] - f0) < 258) begin
            en = ($urandom_range(0, 9) != 0);
            for (int i = 0; i < NI; i++) begin
                if (fn[i] < 2 && $urandom_range(0, 3) != 0) push(i, 3'($urandom_range(0, 7)));
            end
            tick();
            k++;
        end
        chk("wrap_frames_done", int'((frames[0] - f0) >= 258), 1);

        en = 1'b1;
        repeat (60) tick();
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("drained_fifo[%0d]", i), fn[i], 0);
            chk($sformatf("drained_scoreboard[%0d]", i), (et[i] - eh[i] + 8) % 8, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
